// File: rtl/key_word_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_word_gen_if
//  Description : Word-pair input / key-word output handshake bundle for the
//                AES key-expansion word generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface key_word_gen_if;
  logic        iData_valid;   // input word pair valid
  logic        oReady;        // generator can accept an input pair
  logic [31:0] iData;         // w[i-1]
  logic [31:0] iOrigin_data;  // w[i-Nk]
  logic        oData_valid;   // output word valid
  logic        iReady;        // downstream accepts oData
  logic [31:0] oData;         // w[i]
  logic [5:0]  oWord_index;   // i

  // Producer of key words and consumer of generated words (key file side)
  modport master (
    output iData_valid, iData, iOrigin_data, iReady,
    input  oReady, oData_valid, oData, oWord_index
  );

  // The word generator itself
  modport slave (
    input  iData_valid, iData, iOrigin_data, iReady,
    output oReady, oData_valid, oData, oWord_index
  );
endinterface
`default_nettype wire

// File: rtl/key_word_gen.sv
`default_nettype none
// ============================================================================
//  Module      : key_word_gen
//  Description : AES-128/192/256 key-expansion word generator. Produces one
//                schedule word w[i] per accepted (w[i-1], w[i-Nk]) pair with a
//                one-cycle registered latency, on-the-fly Rcon via xtime and a
//                valid/ready handshake with backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_word_gen #(
  parameter int         KEY_WORDS = 4,
  parameter logic [7:0] RCON_INIT = 8'h01
) (
  input  logic           iClk,
  input  logic           iRst_n,
  input  logic           iStart,
  key_word_gen_if.slave  bus,
  output logic           oBusy,
  output logic           oDone
);

  localparam int TOTAL_WORDS = 4 * (KEY_WORDS + 7);

  localparam logic [5:0] c_firstIdx  = 6'(KEY_WORDS);
  localparam logic [5:0] c_lastIdx   = 6'(TOTAL_WORDS - 1);
  localparam logic [2:0] c_lastPhase = 3'(KEY_WORDS - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  // Forward AES S-box, element 0 is the most significant byte of the literal
  localparam logic [0:255][7:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  generate
    if (!(KEY_WORDS == 4 || KEY_WORDS == 6 || KEY_WORDS == 8)) begin : g_badKeyWords
      $error("key_word_gen: KEY_WORDS must be 4, 6 or 8");
    end
  endgenerate

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {c_sbox[w[31:24]], c_sbox[w[23:16]], c_sbox[w[15:8]], c_sbox[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]  r_state;
  logic [1:0]  w_stateNext;
  logic [5:0]  r_count;      // index i of the next word to generate
  logic [2:0]  r_phase;      // i mod Nk
  logic [7:0]  r_rcon;
  logic        r_dataValid;
  logic [31:0] r_data;
  logic [5:0]  r_wordIdx;
  logic        r_done;
  logic [31:0] w_rotWord;
  logic [31:0] w_nextWord;
  logic        w_xfer;
  logic        w_dsAccept;

  assign w_xfer     = (r_state == c_RUN) && bus.iData_valid && bus.oReady;
  assign w_dsAccept = r_dataValid && bus.iReady;

  assign bus.oData_valid = r_dataValid;
  assign bus.oData       = r_data;
  assign bus.oWord_index = r_wordIdx;
  assign oDone           = r_done;

  // State register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= c_IDLE;
    else         r_state <= w_stateNext;
  end

  // Next-state: iStart restarts from any state and wins over a transfer
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_IDLE:  if (iStart) w_stateNext = c_RUN;
      c_RUN: begin
        if (iStart)                                w_stateNext = c_RUN;
        else if (w_xfer && (r_count == c_lastIdx)) w_stateNext = c_DRAIN;
      end
      c_DRAIN: begin
        if (iStart)          w_stateNext = c_RUN;
        else if (w_dsAccept) w_stateNext = c_IDLE;
      end
      default: w_stateNext = c_IDLE;
    endcase
  end

  // State outputs: accept only in RUN when the output slot is free or draining
  always_comb begin
    oBusy      = (r_state != c_IDLE);
    bus.oReady = (r_state == c_RUN) && (!r_dataValid || bus.iReady);
  end

  // Word function selected by the phase within the Nk-word period
  always_comb begin
    w_rotWord  = {bus.iData[23:0], bus.iData[31:24]};
    w_nextWord = bus.iData ^ bus.iOrigin_data;
    if (r_phase == 3'd0)
      w_nextWord = subWord(w_rotWord) ^ {r_rcon, 24'h0} ^ bus.iOrigin_data;
    else if ((KEY_WORDS == 8) && (r_phase == 3'd4))
      w_nextWord = subWord(bus.iData) ^ bus.iOrigin_data;
  end

  // Datapath: word counter, phase, Rcon, output register and done pulse
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_count     <= '0;
      r_phase     <= '0;
      r_rcon      <= RCON_INIT;
      r_dataValid <= 1'b0;
      r_data      <= '0;
      r_wordIdx   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == c_DRAIN) && w_dsAccept && !iStart;
      if (iStart) begin
        // A pending word is dropped on restart
        r_dataValid <= 1'b0;
        r_count     <= c_firstIdx;
        r_phase     <= '0;
        r_rcon      <= RCON_INIT;
      end else if (w_xfer) begin
        r_data      <= w_nextWord;
        r_wordIdx   <= r_count;
        r_dataValid <= 1'b1;
        r_count     <= r_count + 6'd1;
        if (r_phase == c_lastPhase) r_phase <= '0;
        else                        r_phase <= r_phase + 3'd1;
        if (r_phase == 3'd0) r_rcon <= xtime(r_rcon);
      end else if (w_dsAccept) begin
        r_dataValid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
